// File: rtl/inst_gen_pkg.sv
// Shared constants, encodings and helpers for the constrained-random instruction source.
package inst_gen_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned IMM_W  = 12;

  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_NOP = 7'b1111111;

  localparam logic [F3_W-1:0] F3_WORD  = 3'b010;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000007F;
  localparam logic [XLEN-1:0] LFSR_TAPS = 32'h80200003;
  localparam logic [XLEN-1:0] LFSR_INIT = 32'h00000001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_NOP} cls_e;

  // funct7/funct3 pair selected by the op index
  typedef struct packed {
    logic [F7_W-1:0] funct7;
    logic [F3_W-1:0] funct3;
  } op_fn_t;

  typedef struct packed {
    logic [F7_W-1:0]  funct7;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rd;
    logic [OP_W-1:0]  opcode;
  } r_fmt_t;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [REG_W-1:0] rs1;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rd;
    logic [OP_W-1:0]  opcode;
  } i_fmt_t;

  typedef struct packed {
    logic [F7_W-1:0]  imm_hi;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] imm_lo;
    logic [OP_W-1:0]  opcode;
  } s_fmt_t;

  // Instruction class from the low LFSR nibble
  function automatic cls_e inst_class(input logic [3:0] sel);
    cls_e c;
    if (sel <= 4'd5)       c = CLS_R;
    else if (sel <= 4'd11) c = CLS_I;
    else if (sel <= 4'd13) c = CLS_LW;
    else if (sel == 4'd14) c = CLS_SW;
    else                   c = CLS_NOP;
    return c;
  endfunction

  // R-type table: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND MUL MULH MULHSU MULHU
  function automatic op_fn_t r_op(input logic [3:0] idx);
    op_fn_t f;
    case (idx)
      4'd1:    f = '{funct7: 7'b0100000, funct3: 3'b000};
      4'd2:    f = '{funct7: 7'b0000000, funct3: 3'b001};
      4'd3:    f = '{funct7: 7'b0000000, funct3: 3'b010};
      4'd4:    f = '{funct7: 7'b0000000, funct3: 3'b011};
      4'd5:    f = '{funct7: 7'b0000000, funct3: 3'b100};
      4'd6:    f = '{funct7: 7'b0000000, funct3: 3'b101};
      4'd7:    f = '{funct7: 7'b0100000, funct3: 3'b101};
      4'd8:    f = '{funct7: 7'b0000000, funct3: 3'b110};
      4'd9:    f = '{funct7: 7'b0000000, funct3: 3'b111};
      4'd10:   f = '{funct7: 7'b0000001, funct3: 3'b000};
      4'd11:   f = '{funct7: 7'b0000001, funct3: 3'b001};
      4'd12:   f = '{funct7: 7'b0000001, funct3: 3'b010};
      4'd13:   f = '{funct7: 7'b0000001, funct3: 3'b011};
      default: f = '{funct7: 7'b0000000, funct3: 3'b000};
    endcase
    return f;
  endfunction

  // I-type table: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; funct7 only matters for shifts
  function automatic op_fn_t i_op(input logic [3:0] idx);
    op_fn_t f;
    case (idx)
      4'd1:    f = '{funct7: 7'b0000000, funct3: 3'b010};
      4'd2:    f = '{funct7: 7'b0000000, funct3: 3'b011};
      4'd3:    f = '{funct7: 7'b0000000, funct3: 3'b100};
      4'd4:    f = '{funct7: 7'b0000000, funct3: 3'b110};
      4'd5:    f = '{funct7: 7'b0000000, funct3: 3'b111};
      4'd6:    f = '{funct7: 7'b0000000, funct3: 3'b001};
      4'd7:    f = '{funct7: 7'b0000000, funct3: 3'b101};
      4'd8:    f = '{funct7: 7'b0100000, funct3: 3'b101};
      default: f = '{funct7: 7'b0000000, funct3: 3'b000};
    endcase
    return f;
  endfunction

  // One right-shifting Galois step
  function automatic logic [XLEN-1:0] lfsr_step(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/inst_gen_encode.sv
// Combinational encoder: maps the LFSR state (and optional prior rd) to a legal instruction word.
module inst_gen_encode
  import inst_gen_pkg::*;
(
  input  logic [XLEN-1:0] lfsr,
  input  logic [3:0]      prev_rd,
  input  logic            force_rs1,
  output logic [XLEN-1:0] inst
);

  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1_ri;
  logic [REG_W-1:0] rs2;
  op_fn_t           rop;
  op_fn_t           iop;
  logic             is_shift;
  r_fmt_t           r_word;
  i_fmt_t           i_word;
  i_fmt_t           lw_word;
  s_fmt_t           sw_word;

  // Assemble every format in parallel, then select by class
  always_comb begin
    rd       = {1'b0, lfsr[11:8]};
    rs2      = {1'b0, lfsr[19:16]};
    rs1_ri   = force_rs1 ? {1'b0, prev_rd} : {1'b0, lfsr[15:12]};
    rop      = r_op(lfsr[7:4]);
    iop      = i_op(lfsr[7:4]);
    is_shift = (iop.funct3 == 3'b001) || (iop.funct3 == 3'b101);

    r_word.funct7 = rop.funct7;
    r_word.rs2    = rs2;
    r_word.rs1    = rs1_ri;
    r_word.funct3 = rop.funct3;
    r_word.rd     = rd;
    r_word.opcode = OP_R;

    i_word.imm    = is_shift ? {iop.funct7, lfsr[24:20]} : lfsr[31:20];
    i_word.rs1    = rs1_ri;
    i_word.funct3 = iop.funct3;
    i_word.rd     = rd;
    i_word.opcode = OP_I;

    lw_word.imm    = {2'b00, lfsr[29:20]};
    lw_word.rs1    = '0;
    lw_word.funct3 = F3_WORD;
    lw_word.rd     = rd;
    lw_word.opcode = OP_LW;

    sw_word.imm_hi = {2'b00, lfsr[29:25]};
    sw_word.rs2    = rs2;
    sw_word.rs1    = '0;
    sw_word.funct3 = F3_WORD;
    sw_word.imm_lo = lfsr[24:20];
    sw_word.opcode = OP_SW;

    inst = NOP_WORD;
    case (inst_class(lfsr[3:0]))
      CLS_R:   inst = r_word;
      CLS_I:   inst = i_word;
      CLS_LW:  inst = lw_word;
      CLS_SW:  inst = sw_word;
      default: inst = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/inst_stream_gen.sv
// Constrained-random legal instruction source with valid/ready output.
// Optional feature macro: INST_GEN_RAW_BIAS_EN (forces R/I rs1 to the previous rd every 4th word).
module inst_stream_gen
  import inst_gen_pkg::*;
#(
  parameter int unsigned NUM_INST = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  seed,
  output logic [XLEN-1:0]  inst,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  state_e          state;
  state_e          state_nxt;
  logic [XLEN-1:0] lfsr;
  logic [3:0]      prev_rd;
  logic            force_rs1;
  logic            handshake;
  logic            last_word;
  logic            start_ok;

  assign handshake = inst_valid && inst_ready;
  assign last_word = (count == CNT_W'(NUM_INST - 1));
  assign start_ok  = start && (state != RUN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (handshake && last_word) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register
  always_comb begin
    inst_valid = 1'b0;
    done       = 1'b0;
    inst_valid = (state == RUN);
    done       = (state == DONE);
  end

  // LFSR and accepted-word counter: reload on start, advance only on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr  <= LFSR_INIT;
      count <= '0;
    end else if (start_ok) begin
      lfsr  <= (seed == '0) ? LFSR_INIT : seed;
      count <= '0;
    end else if (handshake && (count != CNT_W'(NUM_INST))) begin
      lfsr  <= lfsr_step(lfsr);
      count <= count + CNT_W'(1);
    end
  end

`ifdef INST_GEN_RAW_BIAS_EN
  // Remember the last accepted rd to build read-after-write chains
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          prev_rd <= '0;
    else if (handshake) prev_rd <= inst[10:7];
  end

  assign force_rs1 = (count[1:0] == 2'b11);
`else
  assign prev_rd   = '0;
  assign force_rs1 = 1'b0;
`endif

  inst_gen_encode u_encode (
    .lfsr      (lfsr),
    .prev_rd   (prev_rd),
    .force_rs1 (force_rs1),
    .inst      (inst)
  );

endmodule

// File: tb/tb_inst_stream_gen.sv
// Bench for inst_stream_gen: vector table plus scoreboarded runs.
// Honours INST_GEN_RAW_BIAS_EN when the design is built with it.
module tb_inst_stream_gen;

  localparam int unsigned NUM_INST = 8;
  localparam int unsigned CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      seed;
  logic [31:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic [CNT_W-1:0] count;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          m_count;
  logic [3:0]  mdl_prev;
  logic [31:0] mdl_end_lfsr;
`ifdef INST_GEN_RAW_BIAS_EN
  logic [3:0]  hs_prev;
`endif

  typedef struct {
    logic [31:0] seed;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  inst_stream_gen #(.NUM_INST(NUM_INST), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .count      (count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Reference encoder built from whole-word templates with fields OR-ed in
  function automatic logic [31:0] ref_inst(input logic [31:0] l, input logic [3:0] prev, input bit frc);
    logic [31:0] t;
    logic [31:0] rs1;
    logic [31:0] rd;
    logic [3:0]  cls;
    logic [3:0]  op;
    cls = l[3:0];
    op  = l[7:4];
    rd  = 32'(l[11:8]) << 7;
    rs1 = frc ? (32'(prev) << 15) : (32'(l[15:12]) << 15);
    if (cls <= 4'd5) begin
      case (op)
        4'd1:    t = 32'h40000033;
        4'd2:    t = 32'h00001033;
        4'd3:    t = 32'h00002033;
        4'd4:    t = 32'h00003033;
        4'd5:    t = 32'h00004033;
        4'd6:    t = 32'h00005033;
        4'd7:    t = 32'h40005033;
        4'd8:    t = 32'h00006033;
        4'd9:    t = 32'h00007033;
        4'd10:   t = 32'h02000033;
        4'd11:   t = 32'h02001033;
        4'd12:   t = 32'h02002033;
        4'd13:   t = 32'h02003033;
        default: t = 32'h00000033;
      endcase
      return t | (32'(l[19:16]) << 20) | rs1 | rd;
    end else if (cls <= 4'd11) begin
      case (op)
        4'd1:    t = 32'h00002013;
        4'd2:    t = 32'h00003013;
        4'd3:    t = 32'h00004013;
        4'd4:    t = 32'h00006013;
        4'd5:    t = 32'h00007013;
        4'd6:    t = 32'h00001013;
        4'd7:    t = 32'h00005013;
        4'd8:    t = 32'h40005013;
        default: t = 32'h00000013;
      endcase
      if (op == 4'd6 || op == 4'd7 || op == 4'd8) t = t | (32'(l[24:20]) << 20);
      else                                         t = t | {l[31:20], 20'h0};
      return t | rs1 | rd;
    end else if (cls <= 4'd13) begin
      return 32'h00002003 | (32'(l[29:20]) << 20) | rd;
    end else if (cls == 4'd14) begin
      return 32'h00002023 | (32'(l[29:25]) << 25) | (32'(l[19:16]) << 20) | (32'(l[24:20]) << 7);
    end
    return 32'h0000007F;
  endfunction

  // Independent legality decoder for the accepted subset
  function automatic logic is_legal(input logic [31:0] w);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       rd_ok;
    logic       rs1_ok;
    logic       rs2_ok;
    opc    = w[6:0];
    f7     = w[31:25];
    f3     = w[14:12];
    rd_ok  = !w[11];
    rs1_ok = !w[19];
    rs2_ok = !w[24];
    case (opc)
      7'h33: return rd_ok && rs1_ok && rs2_ok &&
                    (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (f7 == 7'h01 && f3 <= 3'd3));
      7'h13: begin
        if (f3 == 3'd1)      return rd_ok && rs1_ok && f7 == 7'h00;
        else if (f3 == 3'd5) return rd_ok && rs1_ok && (f7 == 7'h00 || f7 == 7'h20);
        else                 return rd_ok && rs1_ok;
      end
      7'h03: return rd_ok && f3 == 3'd2 && w[19:15] == 5'd0 && w[31:30] == 2'b00;
      7'h23: return rs2_ok && f3 == 3'd2 && w[19:15] == 5'd0 && w[31:30] == 2'b00;
      7'h7F: return w == 32'h0000007F;
      default: return 1'b0;
    endcase
  endfunction

  // Start pulse; push the whole run's expected words into the scoreboard
  task automatic start_run(input logic [31:0] s);
    logic [31:0] l;
    logic [31:0] w;
    logic [3:0]  p;
    bit          frc;
    start = 1'b1;
    seed  = s;
    exp_q.delete();
    l = (s == 32'h0) ? 32'h1 : s;
    p = mdl_prev;
    for (int k = 0; k < int'(NUM_INST); k++) begin
      frc = 1'b0;
`ifdef INST_GEN_RAW_BIAS_EN
      frc = ((k % 4) == 3);
`endif
      w = ref_inst(l, p, frc);
      exp_q.push_back(w);
      p = w[10:7];
      l = lfsr_next(l);
    end
    mdl_prev     = p;
    mdl_end_lfsr = l;
    m_count      = 0;
`ifdef INST_GEN_RAW_BIAS_EN
    hs_prev = 4'h0;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // One cycle: drive ready and, if a handshake is about to occur, score it
  task automatic cycle_hs(input bit rdy);
    logic [31:0] e;
    inst_ready = rdy;
    if (inst_valid && rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got word %08h expected none", inst);
      end else begin
        e = exp_q.pop_front();
        check32("count_at_hs", 32'(count), 32'(m_count));
        check32("inst", inst, e);
        check1("legal", is_legal(inst), 1'b1);
`ifdef INST_GEN_RAW_BIAS_EN
        if ((m_count % 4) == 3 && (inst[6:0] == 7'h33 || inst[6:0] == 7'h13))
          check32("raw_rs1", 32'(inst[19:15]), 32'(hs_prev));
        hs_prev = e[10:7];
`endif
        m_count++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input bit rand_ready);
    int cyc;
    cyc = 0;
    while (!done && cyc < 400) begin
      cycle_hs(rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      cyc++;
    end
    inst_ready = 1'b0;
    check1("run_done", done, 1'b1);
    check32("run_count", 32'(count), 32'(NUM_INST));
    check1("run_valid_low", inst_valid, 1'b0);
    check32("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    start      = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_count  = 0;
    mdl_prev = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] base_seeds[4];
    logic [31:0] s;

    vecs[0] = '{seed: 32'h00021310, exp: 32'h402081B3};
    vecs[1] = '{seed: 32'h0000000C, exp: 32'h00002003};
    vecs[2] = '{seed: 32'h0000000F, exp: 32'h0000007F};
    vecs[3] = '{seed: 32'h00000000, exp: 32'h00000033};
    vecs[4] = '{seed: 32'h12345676, exp: 32'h0032D313};
    vecs[5] = '{seed: 32'hABCDE12E, exp: 32'h2AD02E23};
    vecs[6] = '{seed: 32'h000003A0, exp: 32'h020001B3};
    vecs[7] = '{seed: 32'h000054F0, exp: 32'h00028233};
    vecs[8] = '{seed: 32'hFFF03126, exp: 32'hFFF1B093};

    base_seeds[0] = 32'h00000001;
    base_seeds[1] = 32'hDEADBEEF;
    base_seeds[2] = 32'h13579BDF;
    base_seeds[3] = 32'h80000000;

    reset      = 1'b1;
    start      = 1'b0;
    seed       = 32'h0;
    inst_ready = 1'b0;
    m_count    = 0;
    mdl_prev   = 4'h0;
`ifdef INST_GEN_RAW_BIAS_EN
    hs_prev = 4'h0;
`endif

    // Reset state
    @(negedge clk);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_done", done, 1'b0);
    check32("rst_count", 32'(count), 32'd0);
    check32("rst_inst_lfsr1", inst, 32'h00000033);
    reset = 1'b0;
    @(negedge clk);

    // Table: first word of a run for hand-encoded seeds
    foreach (vecs[i]) begin
      do_reset();
      start = 1'b1;
      seed  = vecs[i].seed;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      start = 1'b0;
      check1($sformatf("vec%0d_valid", i), inst_valid, 1'b1);
      if (inst_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32($sformatf("vec%0d_inst", i), inst, e);
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL vec%0d_pop: valid %b, queue %0d, expected a word", i, inst_valid, exp_q.size());
      end
    end

    // Reset in the middle of a run
    do_reset();
    start_run(32'h12345678);
    for (int k = 0; k < 5; k++) cycle_hs(1'b1);
    inst_ready = 1'b0;
    check32("mid_count", 32'(count), 32'd5);
    check1("mid_valid", inst_valid, 1'b1);
    reset = 1'b1;
    #1;
    check1("async_rst_valid", inst_valid, 1'b0);
    check32("async_rst_count", 32'(count), 32'd0);
    check1("async_rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mdl_prev = 4'h0;
    @(negedge clk);
    check32("post_rst_lfsr1", inst, 32'h00000033);
    check1("post_rst_valid", inst_valid, 1'b0);

    // Seed 0 substitutes 1; full run of NUM_INST
    do_reset();
    start_run(32'h0);
    check32("seed0_first", inst, 32'h00000033);
    for (int k = 0; k < int'(NUM_INST); k++) begin
      check1("seed0_done_low", done, 1'b0);
      cycle_hs(1'b1);
    end
    check1("seed0_done", done, 1'b1);
    check32("seed0_count", 32'(count), 32'(NUM_INST));
    check1("seed0_valid_low", inst_valid, 1'b0);
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inst_ready = 1'b0;
    check1("done_hold", done, 1'b1);
    check32("count_hold", 32'(count), 32'(NUM_INST));

    // Stall mid-run with an ignored start pulse
    start_run(32'hCAFEF00D);
    check1("restart_done_clr", done, 1'b0);
    for (int k = 0; k < 3; k++) cycle_hs(1'b1);
    for (int k = 0; k < 5; k++) begin
      check32("stall_inst", inst, exp_q[0]);
      check32("stall_count", 32'(count), 32'd3);
      check1("stall_valid", inst_valid, 1'b1);
      start = (k == 2);
      seed  = 32'h00000001;
      cycle_hs(1'b0);
    end
    start = 1'b0;
    run_until_done(1'b0);

    // Long random-ready runs from several seeds
    foreach (base_seeds[i]) begin
      s = base_seeds[i];
      for (int r = 0; r < 313; r++) begin
        start_run(s);
        run_until_done(1'b1);
        s = mdl_end_lfsr;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
